// File: rtl/reg16_file.sv
// 16-bit register-pair file (BC, DE, WZ, HL, SP, PC) with a shared source bus,
// inc/dec write path and WZ byte loads. Optional REG16_CONFLICT_CHECK_EN adds a
// sticky multi-source read flag with its own clear input.
module reg16_pair #(
  parameter logic [15:0] RST = 16'h0000
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic        i_We_Lo,
  input  logic        i_We_Hi,
  input  logic [15:0] i_D,
  output logic [15:0] o_Q
);
  logic [15:0] r_q;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_q <= RST;
    end else begin
      if (i_We_Lo) r_q[7:0]  <= i_D[7:0];
      if (i_We_Hi) r_q[15:8] <= i_D[15:8];
    end
  end

  assign o_Q = r_q;
endmodule

module reg16_file #(
  parameter logic [15:0] SP_RESET = 16'hFFFE,
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic [5:0]  i_Read16,
  input  logic [5:0]  i_Write16,
  input  logic [1:0]  i_Increment16,
  input  logic        i_Address_Out,
  input  logic [7:0]  i_Data8,
  input  logic        i_Load_Z,
  input  logic        i_Load_W,
`ifdef REG16_CONFLICT_CHECK_EN
  input  logic        i_Conflict_Clear,
`endif
  output logic [15:0] o_Bus16,
  output logic [15:0] o_Address,
  output logic [15:0] o_BC,
  output logic [15:0] o_DE,
  output logic [15:0] o_HL,
  output logic [15:0] o_SP,
  output logic [15:0] o_PC,
  output logic        o_Conflict
);
  localparam int NUM_PAIRS = 6;
  localparam logic [NUM_PAIRS-1:0][15:0] RST_VALS =
    {PC_RESET, SP_RESET, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

  logic [NUM_PAIRS-1:0][15:0] w_pair;
  logic [NUM_PAIRS-1:0][15:0] w_d;
  logic [NUM_PAIRS-1:0]       w_we_lo;
  logic [NUM_PAIRS-1:0]       w_we_hi;
  logic [15:0]                w_bus;
  logic [15:0]                w_wr;
  logic [15:0]                r_address;

  always_comb begin
    w_bus = 16'h0000;
    for (int i = 0; i < NUM_PAIRS; i++)
      if (i_Read16[i]) w_bus = w_bus | w_pair[i];
  end

  always_comb begin
    case (i_Increment16)
      2'b01:   w_wr = w_bus + 16'd1;
      2'b10:   w_wr = w_bus - 16'd1;
      default: w_wr = w_bus;
    endcase
  end

  // A 16-bit write to WZ overrides both byte loads.
  always_comb begin
    w_we_lo = i_Write16;
    w_we_hi = i_Write16;
    w_d     = {NUM_PAIRS{w_wr}};
    if (!i_Write16[2]) begin
      w_we_lo[2] = i_Load_Z;
      w_we_hi[2] = i_Load_W;
      w_d[2]     = {i_Data8, i_Data8};
    end
  end

  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
    reg16_pair #(.RST(RST_VALS[g])) u_pair (
      .i_Clk     (i_Clk),
      .i_Reset_n (i_Reset_n),
      .i_We_Lo   (w_we_lo[g]),
      .i_We_Hi   (w_we_hi[g]),
      .i_D       (w_d[g]),
      .o_Q       (w_pair[g])
    );
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n)         r_address <= 16'h0000;
    else if (i_Address_Out) r_address <= w_bus;
  end

`ifdef REG16_CONFLICT_CHECK_EN
  logic r_conflict;
  logic w_multi;
  assign w_multi = |(i_Read16 & (i_Read16 - 6'd1));

  // Set has priority over clear.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n)            r_conflict <= 1'b0;
    else if (w_multi)          r_conflict <= 1'b1;
    else if (i_Conflict_Clear) r_conflict <= 1'b0;
  end
  assign o_Conflict = r_conflict;
`else
  assign o_Conflict = 1'b0;
`endif

  assign o_Bus16   = w_bus;
  assign o_Address = r_address;
  assign o_BC      = w_pair[0];
  assign o_DE      = w_pair[1];
  assign o_HL      = w_pair[3];
  assign o_SP      = w_pair[4];
  assign o_PC      = w_pair[5];
endmodule

// File: doc/reg16_file.md
# reg16_file

16-bit register-pair file for the CPU datapath: holds BC, DE, WZ, HL, SP and PC and services the one-hot 16-bit read/write strobes issued by the control-unit microcode blocks. One selected pair drives an internal 16-bit bus per cycle. Any number of pairs load that bus value, optionally incremented or decremented. The bus value can be latched onto the memory address output. A byte-load path fills WZ from the 8-bit data bus for immediate operands.

## Interface
Parameters:
- `SP_RESET`, 16'hFFFE: reset value of SP.
- `PC_RESET`, 16'h0000: reset value of PC.

Ports:
- `i_Clk`  in  1  system clock; all state updates on the rising edge.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_Read16`  in  6  one-hot source select. Bit 0 BC, bit 1 DE, bit 2 WZ, bit 3 HL, bit 4 SP, bit 5 PC.
- `i_Write16`  in  6  destination select, same bit mapping; multiple bits allowed.
- `i_Increment16`  in  2  write-path adjust: 2'b01 = +1, 2'b10 = −1, 2'b00 or 2'b11 = pass.
- `i_Address_Out`  in  1  latch the bus value into `o_Address`.
- `i_Data8`  in  8  byte from the data bus.
- `i_Load_Z`  in  1  load `i_Data8` into WZ[7:0].
- `i_Load_W`  in  1  load `i_Data8` into WZ[15:8].
- `i_Conflict_Clear`  in  1  clear `o_Conflict`; present only under the macro.
- `o_Bus16`  out  16  current bus value (combinational).
- `o_Address`  out  16  registered memory address.
- `o_BC`, `o_DE`, `o_HL`, `o_SP`, `o_PC`  out  16 each  register contents, for the 8-bit file and debug.
- `o_Conflict`  out  1  sticky multi-source flag.

## Operation
- Bus: `o_Bus16` is the bitwise OR of all pairs whose `i_Read16` bit is set. If `i_Read16` is 0, the bus is 16'h0000.
- Write value is the bus value adjusted by `i_Increment16`, in modulo 2^16 arithmetic. So 16'hFFFF+1 = 16'h0000 and 16'h0000−1 = 16'hFFFF.
- Every pair with its `i_Write16` bit set loads the write value at the clock edge.
- Reads always return pre-edge contents. A pair may be both source and destination in one cycle; for example, `i_Read16`=`i_Write16`=PC with +1 performs PC++.
- `i_Address_Out` loads the unadjusted bus value into `o_Address`. Otherwise `o_Address` holds its value.
- Byte loads: `i_Load_Z` and `i_Load_W` write the corresponding WZ byte. If `i_Write16[2]` is set in the same cycle, the 16-bit write wins for both bytes. `i_Load_Z` and `i_Load_W` together load the same byte into both halves.
- No state machine beyond the register contents. Each strobe cycle is independent.

## Timing
- Reset (async assert, sync-to-clock release): BC, DE, WZ, HL = 16'h0000. SP = `SP_RESET`. PC = `PC_RESET`. `o_Address` = 16'h0000. `o_Conflict` = 0. `o_Bus16` is 0 while `i_Read16` = 0.
- Reset asserted mid-operation aborts the in-flight write. All state returns to reset values immediately, with no partial update.
- `o_Bus16` has zero latency from `i_Read16`. Register outputs and `o_Address` update 1 cycle after the strobe edge.
- Strobes are level-sampled once per edge. A strobe held N cycles applies N times, e.g. a held +1 write to PC increments N times.

## Configuration
- `REG16_CONFLICT_CHECK_EN` defined:
  - `o_Conflict` sets on any edge where more than one `i_Read16` bit is high, and stays set until `i_Conflict_Clear`.
  - If set and clear occur in the same cycle, set wins.
  - The bus still ORs the selected sources.
- Not defined: `o_Conflict` is tied to 0, the `i_Conflict_Clear` port is absent, and there is no detection logic.

## Test plan
- Reset → BC=DE=WZ=HL=0000, SP=FFFE, PC=0000, `o_Address`=0000, `o_Conflict`=0.
- HL=C123; one cycle with Read16=6'b001000, Write16=6'b100000, Increment16=01, Address_Out=1 → PC=C124, `o_Address`=C123, HL unchanged.
- SP=0000; Read16=Write16=SP, Increment16=10 → SP=FFFF. Then PC=FFFF with +1 in place → PC=0000.
- Cycle 1: Load_Z with Data8=34. Cycle 2: Load_W with Data8=12 → WZ=1234. Then Load_Z=1 with Write16[2]=1 and bus=BEEF → WZ=BEEF.
- Read16=6'b000011 with BC=00F0, DE=0F00 → bus=0FF0. With the macro defined, `o_Conflict`=1 next cycle and stays 1 until `i_Conflict_Clear`. Without the macro, `o_Conflict` stays 0.
- Write16=6'b110000 from HL=8000, then assert `i_Reset_n` low mid-cycle → SP=FFFE and PC=0000 immediately; the pending write is lost.
